// File: rtl/decode_issue.sv
// rtl/decode_issue.sv - instruction decode, scoreboard hazard check and single-slot issue
module decode_issue #(
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  issue_rd,
  output logic        issue_we,
  output logic        issue_valid,
  input  logic        issue_ready,
  input  logic        wb_en,
  input  logic [1:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        illegal_op
);

  logic [15:0] regs [4];
  logic [3:0]  pending;
  logic [3:0]  pending_nxt;

  logic [3:0]  opc;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [1:0]  rt;
  logic [7:0]  imm8;

  assign opc  = instr[15:12];
  assign rd   = instr[11:10];
  assign rs   = instr[9:8];
  assign rt   = instr[7:6];
  assign imm8 = instr[7:0];

  // Writeback landing on a field this cycle
  logic wb_hit_s;
  logic wb_hit_t;
  logic wb_hit_d;

  assign wb_hit_s = wb_en && (wb_addr == rs);
  assign wb_hit_t = wb_en && (wb_addr == rt);
  assign wb_hit_d = wb_en && (wb_addr == rd);

  // Source values, forwarded from the writeback port when bypass is enabled
  logic [15:0] val_s;
  logic [15:0] val_t;

  assign val_s = ((BYPASS != 0) && wb_hit_s) ? wb_data : regs[rs];
  assign val_t = ((BYPASS != 0) && wb_hit_t) ? wb_data : regs[rt];

  // Without bypass a same-cycle writeback still counts as busy: the register
  // file only holds the new value after the edge.
  logic busy_s;
  logic busy_t;
  logic busy_d;

  assign busy_s = (pending[rs] && !wb_hit_s) || ((BYPASS == 0) && wb_hit_s);
  assign busy_t = (pending[rt] && !wb_hit_t) || ((BYPASS == 0) && wb_hit_t);
  assign busy_d = pending[rd] && !wb_hit_d;

  logic        use_rs;
  logic        use_rt;
  logic        writes;
  logic        illegal;
  logic [3:0]  d_op;
  logic [15:0] d_a;
  logic [15:0] d_b;

  // Opcode decode: operand selection, ALU op and register usage
  always_comb begin
    use_rs  = 1'b1;
    use_rt  = 1'b0;
    writes  = 1'b1;
    illegal = 1'b0;
    d_op    = opc;
    d_a     = val_s;
    d_b     = 16'h0000;
    case (opc)
      4'd0, 4'd1, 4'd2, 4'd3: begin
        use_rt = 1'b1;
        d_b    = val_t;
      end
      4'd4, 4'd5, 4'd6, 4'd7: begin
        d_b = 16'h0000;
      end
      4'd8: begin
        use_rs = 1'b0;
        d_a    = 16'h0000;
        d_b    = {8'h00, imm8};
      end
      4'd9, 4'd10: begin
        use_rt = 1'b1;
        writes = 1'b0;
        d_b    = val_t;
      end
      4'd11, 4'd12: begin
        writes = 1'b0;
      end
      4'd13: begin
        d_op = 4'd0;
        d_b  = {{8{imm8[7]}}, imm8};
      end
      4'd14: begin
        d_op = 4'd3;
        d_b  = {8'h00, imm8};
      end
      default: begin
        illegal = 1'b1;
        use_rs  = 1'b0;
        writes  = 1'b0;
        d_op    = 4'd0;
        d_a     = 16'h0000;
      end
    endcase
  end

  logic hazard;
  logic accept;
  logic issue;

  assign hazard      = (use_rs && busy_s) || (use_rt && busy_t) || (writes && busy_d);
  assign instr_ready = rst_n && (!issue_valid || issue_ready) && (illegal || !hazard);
  assign accept      = instr_valid && instr_ready;
  assign issue       = accept && !illegal;

  // Scoreboard next state: writeback clears, a new writer sets (set wins)
  always_comb begin
    pending_nxt = pending;
    if (wb_en) begin
      pending_nxt[wb_addr] = 1'b0;
    end
    if (issue && writes) begin
      pending_nxt[rd] = 1'b1;
    end
  end

  // Scoreboard and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 16'h0000;
      end
    end else begin
      pending <= pending_nxt;
      if (wb_en) begin
        regs[wb_addr] <= wb_data;
      end
    end
  end

  // Issue slot: load on a legal accept, drain when taken, hold while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      alu_a       <= 16'h0000;
      alu_b       <= 16'h0000;
      alu_op      <= 4'd0;
      issue_rd    <= 2'd0;
      issue_we    <= 1'b0;
    end else if (issue) begin
      issue_valid <= 1'b1;
      alu_a       <= d_a;
      alu_b       <= d_b;
      alu_op      <= d_op;
      issue_rd    <= rd;
      issue_we    <= writes;
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

  // One-cycle flag for a consumed illegal opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept && illegal;
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// tb/tb_decode_issue.sv - directed self-checking bench for decode_issue
module tb_decode_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_op;
  logic [1:0]  issue_rd;
  logic        issue_we;
  logic        issue_valid;
  logic        issue_ready;
  logic        wb_en;
  logic [1:0]  wb_addr;
  logic [15:0] wb_data;
  logic        illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  decode_issue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .issue_rd    (issue_rd),
    .issue_we    (issue_we),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [1:0] a, input logic [15:0] d);
    wb_en   = 1'b1;
    wb_addr = a;
    wb_data = d;
    step();
    wb_en   = 1'b0;
  endtask

  task automatic offer(input logic [15:0] i);
    instr_valid = 1'b1;
    instr       = i;
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    issue_ready = 1'b1;
    wb_en       = 1'b0;
    wb_addr     = 2'd0;
    wb_data     = 16'h0000;

    #12;
    check("rst_issue_valid", {15'b0, issue_valid}, 16'h0000);
    check("rst_alu_a", alu_a, 16'h0000);
    check("rst_illegal", {15'b0, illegal_op}, 16'h0000);
    check("rst_pending", {12'b0, dut.pending}, 16'h0000);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", {15'b0, instr_ready}, 16'h0001);

    // ADD r0 = r1 + r2 after loading r1=5, r2=3
    wb(2'd1, 16'd5);
    wb(2'd2, 16'd3);
    offer(16'h0180);
    check("add_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    instr_valid = 1'b0;
    check("add_a", alu_a, 16'd5);
    check("add_b", alu_b, 16'd3);
    check("add_op", {12'b0, alu_op}, 16'd0);
    check("add_we", {15'b0, issue_we}, 16'h0001);
    check("add_valid", {15'b0, issue_valid}, 16'h0001);
    check("add_pending", {12'b0, dut.pending}, 16'h0001);

    // SUB r3 = r0 - r1 stalls on pending r0, accepted with bypass in wb cycle
    offer(16'h1C40);
    check("sub_haz_ready", {15'b0, instr_ready}, 16'h0000);
    step();
    check("sub_haz_drain", {15'b0, issue_valid}, 16'h0000);
    wb_en   = 1'b1;
    wb_addr = 2'd0;
    wb_data = 16'd7;
    #1;
    check("sub_byp_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    instr_valid = 1'b0;
    wb_en       = 1'b0;
    check("sub_a", alu_a, 16'd7);
    check("sub_b", alu_b, 16'd5);
    check("sub_op", {12'b0, alu_op}, 16'd1);
    check("sub_rd", {14'b0, issue_rd}, 16'd3);
    check("sub_pending", {12'b0, dut.pending}, 16'h0008);

    // ADI sign-extends, ORI zero-extends
    offer(16'hD9FE);
    step();
    check("adi_a", alu_a, 16'd5);
    check("adi_b", alu_b, 16'hFFFE);
    check("adi_op", {12'b0, alu_op}, 16'd0);
    offer(16'hE5FE);
    check("ori_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    instr_valid = 1'b0;
    check("ori_b", alu_b, 16'h00FE);
    check("ori_op", {12'b0, alu_op}, 16'd3);
    check("ori_pending", {12'b0, dut.pending}, 16'h000E);

    wb(2'd1, 16'd5);
    wb(2'd2, 16'd3);
    wb(2'd3, 16'd9);
    check("wb_clear_pending", {12'b0, dut.pending}, 16'h0000);

    // LI, then a non-writing compare whose rd is pending
    offer(16'h8334);
    step();
    check("li_a", alu_a, 16'h0000);
    check("li_b", alu_b, 16'h0034);
    check("li_op", {12'b0, alu_op}, 16'd8);
    offer(16'hA180);
    check("cmp_rd_ignored", {15'b0, instr_ready}, 16'h0001);
    step();
    check("cmp_op", {12'b0, alu_op}, 16'd10);
    check("cmp_we", {15'b0, issue_we}, 16'h0000);

    // Downstream stall for 3 cycles, then back-to-back issue
    issue_ready = 1'b0;
    offer(16'h4600);
    for (int i = 0; i < 3; i++) begin
      check("stall_ready", {15'b0, instr_ready}, 16'h0000);
      step();
      check("stall_op", {12'b0, alu_op}, 16'd10);
      check("stall_a", alu_a, 16'd5);
      check("stall_valid", {15'b0, issue_valid}, 16'h0001);
    end
    issue_ready = 1'b1;
    #1;
    check("unstall_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    check("un_op", {12'b0, alu_op}, 16'd4);
    check("un_a", alu_a, 16'd3);
    check("un_b", alu_b, 16'd0);
    check("un_rd", {14'b0, issue_rd}, 16'd1);
    offer(16'hB300);
    check("b2b_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    check("b2b_op", {12'b0, alu_op}, 16'd11);
    check("b2b_a", alu_a, 16'd9);
    check("b2b_we", {15'b0, issue_we}, 16'h0000);

    // Illegal opcode ignores hazards, pulses once, issues nothing
    offer(16'hF000);
    check("ill_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    instr_valid = 1'b0;
    check("ill_pulse", {15'b0, illegal_op}, 16'h0001);
    check("ill_valid", {15'b0, issue_valid}, 16'h0000);
    check("ill_pending", {12'b0, dut.pending}, 16'h0003);
    step();
    check("ill_pulse_end", {15'b0, illegal_op}, 16'h0000);

    // Reset in the middle of a stall
    offer(16'h2BC0);
    step();
    instr_valid = 1'b0;
    issue_ready = 1'b0;
    step();
    check("pre_rst_valid", {15'b0, issue_valid}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {15'b0, issue_valid}, 16'h0000);
    check("mid_rst_a", alu_a, 16'h0000);
    check("mid_rst_b", alu_b, 16'h0000);
    check("mid_rst_op", {12'b0, alu_op}, 16'd0);
    check("mid_rst_we", {15'b0, issue_we}, 16'h0000);
    check("mid_rst_pending", {12'b0, dut.pending}, 16'h0000);
    rst_n = 1'b1;
    offer(16'h5C00);
    check("after_rst_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    instr_valid = 1'b0;
    check("after_rst_op", {12'b0, alu_op}, 16'd5);
    check("after_rst_a", alu_a, 16'h0000);
    check("after_rst_valid", {15'b0, issue_valid}, 16'h0001);
    check("after_rst_pending", {12'b0, dut.pending}, 16'h0008);

    // Set wins over a same-cycle clear of the same register
    issue_ready = 1'b1;
    wb_en       = 1'b1;
    wb_addr     = 2'd3;
    wb_data     = 16'd1;
    offer(16'h6D00);
    check("setwin_ready", {15'b0, instr_ready}, 16'h0001);
    step();
    instr_valid = 1'b0;
    wb_en       = 1'b0;
    check("setwin_pending", {12'b0, dut.pending}, 16'h0008);
    check("setwin_op", {12'b0, alu_op}, 16'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
